// File: rtl/usb_rst_sequencer_pkg.sv
// Shared types and constants for the USB host-controller reset sequencer.
package usb_rst_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RECOVER = 2'd1,
    ST_READY   = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // Width needed for a timer that must reach max(a, b) - 1.
  function automatic int timer_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM slave bus between the Nios II driver and the reset sequencer.
interface usb_rst_sequencer_if;
  // Zero-wait-state Avalon: readdata is valid combinationally whenever
  // chipselect is high; a write lands on the clk edge where chipselect & ~write_n.
  logic        chipselect;
  logic [1:0]  address;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/usb_rst_timer.sv
// Loadable up-counter with terminal-count flag; optionally holds at the terminal value.
module usb_rst_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(sat && tc)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/usb_rst_sequencer.sv
// Drives the USB host-controller reset pin with a minimum pulse width and a
// recovery delay, with an Avalon-MM status/control/count register block.
module usb_rst_sequencer
  import usb_rst_sequencer_pkg::*;
#(
  parameter int RESET_CYCLES   = 8,
  parameter int RECOVER_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_in,
  usb_rst_sequencer_if.slave   bus,
  output logic                 usb_rst_n,
  output logic                 usb_ready,
  output logic [1:0]           dbg_state
);

  localparam int TW = timer_width(RESET_CYCLES, RECOVER_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               req_q_q, req_q_d;
  logic               sticky_q, sticky_d;
  logic               usb_rst_n_q, usb_rst_n_d;
  logic               usb_ready_q, usb_ready_d;

  logic               wr_en, sw_trig, trig, sticky_clr, abort;
  logic               timer_clr, timer_inc, timer_tc;
  logic [TW-1:0]      timer_term;
  logic               unused_bus;

  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign sw_trig    = wr_en & (bus.address == ADDR_CTRL) & bus.writedata[0];
  assign sticky_clr = wr_en & (bus.address == ADDR_STATUS) & bus.writedata[2];
  assign trig       = (req_in & ~req_q_q) | sw_trig;
  assign unused_bus = ^{bus.read_n, bus.writedata[31:3], bus.writedata[1]};

  // One timer serves both phases; it saturates only while the pulse is held.
  assign timer_term = (state_q == ST_ASSERT) ? TW'(RESET_CYCLES - 1) : TW'(RECOVER_CYCLES - 1);

  usb_rst_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .sat     (state_q == ST_ASSERT),
    .term    (timer_term),
    .tc      (timer_tc)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        timer_inc = 1'b1;
        if (timer_tc && !req_in) begin
          state_d   = ST_RECOVER;
          timer_clr = 1'b1;
        end
      end
      ST_RECOVER: begin
        timer_inc = 1'b1;
        if (timer_tc) begin
          state_d   = ST_READY;
          timer_clr = 1'b1;
          count_d   = count_q + CNT_W'(1);
        end
      end
      ST_READY: timer_clr = 1'b1;
      default: begin
        state_d   = ST_ASSERT;
        timer_clr = 1'b1;
      end
    endcase
    // A trigger overrides any transition, including a completing recovery.
    if (trig) begin
      state_d   = ST_ASSERT;
      timer_clr = 1'b1;
      count_d   = count_q;
      abort     = (state_q == ST_RECOVER);
    end
  end

  assign req_q_d     = req_in;
  assign sticky_d    = abort | (sticky_q & ~sticky_clr);
  assign usb_rst_n_d = (state_d != ST_ASSERT);
  assign usb_ready_d = (state_d == ST_READY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ASSERT;
      count_q     <= '0;
      req_q_q     <= 1'b0;
      sticky_q    <= 1'b0;
      usb_rst_n_q <= 1'b0;
      usb_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_q_q     <= req_q_d;
      sticky_q    <= sticky_d;
      usb_rst_n_q <= usb_rst_n_d;
      usb_ready_q <= usb_ready_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_STATUS: bus.readdata = {27'd0, state_q, sticky_q, (state_q != ST_READY), usb_ready_q};
        ADDR_COUNT:  bus.readdata = 32'(count_q);
        default:     bus.readdata = '0;
      endcase
    end
  end

  assign usb_rst_n = usb_rst_n_q;
  assign usb_ready = usb_ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Self-checking bench for usb_rst_sequencer against an elapsed-time reference model.
module tb_usb_rst_sequencer;
  import usb_rst_sequencer_pkg::*;

  localparam int RC = 8;
  localparam int RV = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_in = 1'b0;
  logic usb_rst_n, usb_ready;
  logic [1:0] dbg_state;

  usb_rst_sequencer_if bus();

  usb_rst_sequencer #(.RESET_CYCLES(RC), .RECOVER_CYCLES(RV), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_in    (req_in),
    .bus       (bus),
    .usb_rst_n (usb_rst_n),
    .usb_ready (usb_ready),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Reference model: time since the last sequence start, and time since release.
  int          m_since, m_age;
  bit          m_released, m_ready, m_sticky, m_req_prev;
  int unsigned m_count;

  task automatic model_reset();
    m_since = 0; m_age = 0; m_released = 0; m_ready = 0;
    m_sticky = 0; m_req_prev = 0; m_count = 0;
  endtask

  task automatic model_edge();
    bit wr, trig, clr, abort;
    wr    = bus.chipselect && !bus.write_n;
    trig  = (req_in && !m_req_prev) || (wr && bus.address == ADDR_CTRL && bus.writedata[0]);
    clr   = wr && bus.address == ADDR_STATUS && bus.writedata[2];
    abort = trig && m_released && !m_ready;
    if (trig) begin
      m_since = 0; m_age = 0; m_released = 0; m_ready = 0;
    end else if (!m_released) begin
      if (m_since + 1 >= RC && !req_in) begin m_released = 1; m_age = 0; end
      else m_since++;
    end else if (!m_ready) begin
      if (m_age + 1 >= RV) begin m_ready = 1; m_count = (m_count + 1) % (1 << CW); end
      else m_age++;
    end
    if (abort) m_sticky = 1;
    else if (clr) m_sticky = 0;
    m_req_prev = req_in;
  endtask

  function automatic logic [1:0] m_enc();
    return m_ready ? 2'd2 : (m_released ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [31:0] exp_read(logic [1:0] addr);
    logic [31:0] v;
    v = '0;
    if (addr == ADDR_STATUS) v = {27'd0, m_enc(), m_sticky, !m_ready, m_ready};
    else if (addr == ADDR_COUNT) v = 32'(m_count);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (reset_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(logic [1:0] addr, logic [31:0] data);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = addr; bus.writedata = data;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
  endtask

  task automatic bus_read(logic [1:0] addr, output logic [31:0] data);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = addr;
    #1;
    data = bus.readdata;
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic wait_recover_age(int age, output bit ok);
    int n = 0;
    while (!(m_released && !m_ready && m_age == age) && n < 200) begin tick(); n++; end
    ok = (n < 200);
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!m_ready && n < 200) begin tick(); n++; end
    ok = (n < 200);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (usb_rst_n !== 1'b0 || usb_ready !== 1'b0) begin
      failures++; $display("FAIL reset_pins: got rst_n=%b ready=%b expected 0 0", usb_rst_n, usb_ready);
    end
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL reset_status: got %h expected %h", d, 32'h2); end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_count: got %h expected 0", d); end
  endtask

  task automatic test_powerup(string tag, int expect_count);
    int rise = -1, rdy = -1;
    logic [31:0] d;
    reset_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (usb_rst_n !== m_released || usb_ready !== m_ready) begin
        failures++;
        $display("FAIL %s_track c=%0d: got rst_n=%b ready=%b expected %b %b", tag, c, usb_rst_n, usb_ready, m_released, m_ready);
      end
      if (usb_rst_n === 1'b1 && rise < 0) rise = c;
      if (usb_ready === 1'b1 && rdy < 0) rdy = c;
    end
    checks++;
    if (rise != RC) begin failures++; $display("FAIL %s_pulse_width: got %0d expected %0d", tag, rise, RC); end
    checks++;
    if (rdy - rise != RV) begin failures++; $display("FAIL %s_recover: got %0d expected %0d", tag, rdy - rise, RV); end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== 32'(expect_count)) begin failures++; $display("FAIL %s_count: got %h expected %h", tag, d, expect_count); end
  endtask

  task automatic test_level_extension();
    int low = 0, n = 0;
    logic [31:0] d;
    req_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (usb_rst_n === 1'b0) low++;
    end
    req_in = 1'b0;
    tick();
    checks++;
    if (low != 20 || usb_rst_n !== 1'b1) begin
      failures++; $display("FAIL level_width: got low=%0d rst_n=%b expected 20 1", low, usb_rst_n);
    end
    while (usb_ready !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != RV) begin failures++; $display("FAIL level_recover: got %0d expected %0d", n, RV); end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL level_count: got %h expected 2", d); end
  endtask

  task automatic test_abort_recover();
    bit ok;
    logic [31:0] d;
    int unsigned c0 = m_count;
    bus_write(ADDR_CTRL, 32'h1);
    wait_recover_age(5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_wait: got timeout expected recover"); end
    bus_write(ADDR_CTRL, 32'h1);
    checks++;
    if (dbg_state !== 2'd0 || usb_rst_n !== 1'b0) begin
      failures++; $display("FAIL abort_state: got state=%0d rst_n=%b expected 0 0", dbg_state, usb_rst_n);
    end
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d[2] !== 1'b1 || d !== exp_read(ADDR_STATUS)) begin
      failures++; $display("FAIL abort_status: got %h expected %h", d, exp_read(ADDR_STATUS));
    end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== 32'(c0)) begin failures++; $display("FAIL abort_count_hold: got %h expected %h", d, c0); end
    wait_ready(ok);
    bus_read(ADDR_COUNT, d);
    checks++;
    if (!ok || usb_ready !== 1'b1 || d !== 32'((c0 + 1) % 4)) begin
      failures++; $display("FAIL abort_complete: got ready=%b count=%h expected 1 %h", usb_ready, d, (c0 + 1) % 4);
    end
  endtask

  task automatic test_collision();
    bit ok;
    logic [31:0] d;
    int unsigned c0 = m_count;
    bus_write(ADDR_STATUS, 32'h4);
    bus_write(ADDR_CTRL, 32'h1);
    wait_recover_age(RV - 1, ok);
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    checks++;
    if (!ok || dbg_state !== 2'd0 || usb_rst_n !== 1'b0 || usb_ready !== 1'b0) begin
      failures++; $display("FAIL collide_state: got state=%0d rst_n=%b ready=%b expected 0 0 0", dbg_state, usb_rst_n, usb_ready);
    end
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d[2] !== 1'b1) begin failures++; $display("FAIL collide_sticky: got %b expected 1", d[2]); end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== 32'(c0)) begin failures++; $display("FAIL collide_count: got %h expected %h", d, c0); end
    bus_write(ADDR_STATUS, 32'h4);
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d[2] !== 1'b0) begin failures++; $display("FAIL sticky_clear: got %b expected 0", d[2]); end
    wait_ready(ok);
  endtask

  task automatic test_wrap_reserved();
    bit ok;
    logic [31:0] d, st0, cnt0;
    int unsigned c0 = m_count;
    for (int s = 0; s < 4; s++) begin
      bus_write(ADDR_CTRL, 32'h1);
      wait_ready(ok);
    end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (!ok || d !== 32'(c0)) begin failures++; $display("FAIL wrap_count: got %h expected %h", d, c0); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reserved_read: got %h expected 0", d); end
    bus_read(ADDR_CTRL, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL ctrl_read: got %h expected 0", d); end
    st0 = exp_read(ADDR_STATUS);
    cnt0 = exp_read(ADDR_COUNT);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick();
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== st0 || usb_ready !== 1'b1) begin failures++; $display("FAIL reserved_write_status: got %h expected %h", d, st0); end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== cnt0) begin failures++; $display("FAIL reserved_write_count: got %h expected %h", d, cnt0); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [1:0] addr;
    bit ok;
    for (int i = 0; i < 800; i++) begin
      checks++;
      if (usb_rst_n !== m_released || usb_ready !== m_ready || dbg_state !== m_enc()) begin
        failures++;
        $display("FAIL rand_pins i=%0d: got %b%b st=%0d expected %b%b st=%0d", i, usb_rst_n, usb_ready, dbg_state, m_released, m_ready, m_enc());
      end
      if ($urandom_range(0, 29) == 0) req_in = ~req_in;
      addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        bus_write(addr, $urandom);
      end else begin
        exp_q.push_back(exp_read(addr));
        bus_read(addr, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin failures++; $display("FAIL rand_read i=%0d addr=%0d: got %h expected %h", i, addr, d, e); end
        tick();
      end
    end
    req_in = 1'b0;
    tick();
    wait_ready(ok);
    checks++;
    if (!ok || usb_ready !== 1'b1) begin failures++; $display("FAIL rand_settle: got ready=%b expected 1", usb_ready); end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [31:0] d;
    bus_write(ADDR_CTRL, 32'h1);
    wait_recover_age(7, ok);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (!ok || usb_rst_n !== 1'b0 || usb_ready !== 1'b0) begin
      failures++; $display("FAIL async_pins: got rst_n=%b ready=%b expected 0 0", usb_rst_n, usb_ready);
    end
    bus_read(ADDR_COUNT, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL async_count: got %h expected 0", d); end
    bus_read(ADDR_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL async_status: got %h expected 2", d); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_powerup("async", 1);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.address = 2'd0; bus.writedata = '0;
    test_reset();
    @(posedge clk); #1;
    test_powerup("powerup", 1);
    test_level_extension();
    test_abort_recover();
    test_collision();
    test_wrap_reserved();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_rst_sequencer.md
Name: usb_rst_sequencer

Overview:
- Consumes the single-bit reset request from the USB-reset PIO output and drives the physical reset pin of the external USB host controller.
- Guarantees a minimum reset-pulse width and a post-reset recovery delay before reporting the controller as ready.
- Provides an Avalon-MM slave so the Nios II driver can poll status, count completed resets and fire a software-triggered reset.
- Sits between the PIO and the top-level USB reset pad.

Parameters:
- RESET_CYCLES, 8, minimum clk cycles usb_rst_n is held low per sequence (≥1)
- RECOVER_CYCLES, 16, clk cycles after usb_rst_n release before usb_ready asserts (≥1)
- CNT_W, 16, width of the completed-sequence counter (≤32)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low system reset
- req_in  in  1  reset request level from the PIO out_port; active high
- chipselect  in  1  Avalon slave select
- address  in  2  Avalon word address
- read_n  in  1  Avalon read strobe, active low
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, zero wait states
- usb_rst_n  out  1  reset pin to the USB controller, active low, registered
- usb_ready  out  1  high when the controller is out of reset and recovered, registered

Behaviour:
- Clock and reset: clk is the clock. reset_n is asynchronous, active-low. All flops clear on reset_n low.
- Reset values: state=ASSERT, timer=0, count=0, req_q=0, usb_rst_n=0, usb_ready=0, sticky=0.
- Power-up: a full sequence runs automatically after reset_n deasserts.
- Trigger: trig = (req_in & ~req_q) | sw_trig.
  - req_q is req_in delayed by one clk.
  - sw_trig = chipselect & ~write_n & address==1 & writedata[0].
- States:
  - ASSERT: usb_rst_n=0, usb_ready=0; timer increments each cycle.
    - Go to RECOVER when timer==RESET_CYCLES-1 and req_in==0; timer clears.
    - While req_in==1, hold ASSERT with timer saturated at RESET_CYCLES-1. Level extends the pulse.
  - RECOVER: usb_rst_n=1, usb_ready=0; timer increments.
    - Go to READY when timer==RECOVER_CYCLES-1; count increments.
  - READY: usb_rst_n=1, usb_ready=1; timer idle at 0.
- Output timing: usb_rst_n and usb_ready are registered decodes of the next state. They change in the same cycle the state register changes.
- trig in any state goes to ASSERT with timer=0, in the following cycle.
  - trig in ASSERT restarts the minimum width.
  - trig in RECOVER aborts recovery; count does not increment.
  - trig on the same cycle as a RECOVER→READY transition: trig wins; no count increment.
- count wraps modulo 2^CNT_W.
- sticky (bit 2 of STATUS) sets whenever a sequence is aborted by trig in RECOVER. It clears on a write to address 0 with writedata[2]=1. If set and clear coincide, set wins.
- Register map (readdata is zero for unlisted bits and addresses):
  - addr 0 STATUS, R/W1C: [0]=usb_ready, [1]=busy (state!=READY), [2]=sticky abort, [4:3]=state encoding (ASSERT=0, RECOVER=1, READY=2).
  - addr 1 CTRL, W: [0]=1 fires sw_trig. Reads return 0.
  - addr 2 COUNT, R: {zero-extend, count}.
  - addr 3: reserved, reads 0, writes ignored.
- Read/write handshake: readdata is valid whenever chipselect is high; read_n is only decoded for completeness. Writes take effect at the clk edge where chipselect & ~write_n.
- reset_n low mid-sequence aborts immediately to the reset values.

Decomposition:
- Shared package: state enum (ST_ASSERT=2'd0, ST_RECOVER=2'd1, ST_READY=2'd2) and register address constants (ADDR_STATUS=0, ADDR_CTRL=1, ADDR_COUNT=2).
- One natural sub-module, usb_rst_timer: a loadable up-counter with terminal-count flag and saturate option, used by both ASSERT and RECOVER.
- Avalon decode and FSM stay in the top module.

Test Plan:
- Power-up: release reset_n at t0, req_in=0. usb_rst_n stays 0 for exactly 8 cycles, then is 1. usb_ready rises 16 cycles later. COUNT reads 1.
- Level extension: in READY, raise req_in for 20 cycles. usb_rst_n goes low 1 cycle after the edge and stays low until 1 cycle after req_in falls (≥20 cycles). READY is reached 16 cycles later; COUNT reads 2.
- Abort in recovery: write CTRL=1 at RECOVER timer=5. The next cycle shows state ASSERT and usb_rst_n=0. STATUS[2]=1; COUNT is unchanged until the new sequence completes.
- Collision: pulse req_in on the exact cycle RECOVER timer==15. The sequence restarts, COUNT does not increment, and sticky=1. Writing 0x4 to addr 0 then reads STATUS[2]=0.
- Wrap and reserved: with CNT_W=2, run 4 full sequences; COUNT reads 0. A read of addr 3 returns 0x00000000, and a write to addr 3 changes nothing.
- Async reset: assert reset_n mid-RECOVER, off-edge. usb_rst_n=0, usb_ready=0 and COUNT=0 immediately; a fresh 8+16 sequence follows release.
